// File: rtl/tms_pmem_arbiter.sv
// tms_pmem_arbiter: shares the single-port program SRAM between the core
// instruction-fetch port and the management Wishbone slave. The core has
// priority. A Wishbone access that keeps losing is forced through once it has
// waited MAX_WAIT cycles. Every access returns data exactly one cycle after issue.
module tms_pmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int MAX_WAIT = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              core_halt,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [7:0]        fetch_data,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_csb,
  output logic              mem_web,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  localparam logic [2:0] MAX_WAIT_C = 3'(MAX_WAIT);

  logic              core_elig;
  logic              wb_elig;
  logic              grant_core;
  logic              grant_wb;
  logic              wb_touches_mem;
  logic              read_ack;
  logic [ADDR_W-1:0] wb_word_addr;
  logic [2:0]        starve_cnt_reg;
  logic [2:0]        starve_cnt_next;
  logic              fetch_pend_reg;
  logic              ack_pend_reg;
  logic              ack_read_reg;

  // Bus bits that carry no meaning here (byte lanes 1-3, sub-word and aliased
  // address bits, upper write data) are collected so their non-use is explicit.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wbs_sel_i[3:1], wbs_adr_i[31:ADDR_W+2],
                             wbs_adr_i[1:0], wbs_dat_i[31:8]};

  // Wishbone addresses are word-aligned bytes; upper bits alias.
  assign wb_word_addr = wbs_adr_i[ADDR_W+1:2];

  // Pulses from accesses in flight are masked while reset is high, so an
  // access caught by reset never produces a valid or an ack.
  assign fetch_valid = fetch_pend_reg & ~wb_rst_i;
  assign wbs_ack_o   = ack_pend_reg & ~wb_rst_i;
  assign read_ack    = wbs_ack_o & ack_read_reg;

  // Data outputs carry the SRAM byte only during their own pulse, zero otherwise.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_data_lane
      assign fetch_data[gi] = fetch_valid & mem_dout[gi];
      assign wbs_dat_o[gi]  = read_ack & mem_dout[gi];
    end
  endgenerate
  assign wbs_dat_o[31:8] = '0;

  // Eligibility and single-winner arbitration; the starved WB request overrides the core.
  always_comb begin
    core_elig  = fetch_req & ~core_halt & ~wb_rst_i;
    wb_elig    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wb_rst_i;
    grant_wb   = wb_elig & ((starve_cnt_reg == MAX_WAIT_C) | ~core_elig);
    grant_core = core_elig & ~grant_wb;
  end

  // A masked byte write is granted and acked but never touches the SRAM.
  assign wb_touches_mem = ~wbs_we_i | wbs_sel_i[0];

  // Combinational SRAM issue for the winner of this cycle.
  always_comb begin
    mem_csb  = 1'b1;
    mem_web  = 1'b1;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_wb) begin
      if (wb_touches_mem) begin
        mem_csb  = 1'b0;
        mem_web  = ~wbs_we_i;
        mem_addr = wb_word_addr;
        if (wbs_we_i) begin
          mem_din = wbs_dat_i[7:0];
        end
      end
    end else if (grant_core) begin
      mem_csb  = 1'b0;
      mem_addr = fetch_addr;
    end
  end

  // Starvation counter: counts lost WB cycles, saturates, clears when WB wins or leaves.
  always_comb begin
    starve_cnt_next = '0;
    if (wb_elig && !grant_wb) begin
      if (starve_cnt_reg != MAX_WAIT_C) begin
        starve_cnt_next = starve_cnt_reg + 3'd1;
      end else begin
        starve_cnt_next = starve_cnt_reg;
      end
    end
  end

  // State registers: the in-flight flags drive the next-cycle response pulses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      starve_cnt_reg <= '0;
      fetch_pend_reg <= 1'b0;
      ack_pend_reg   <= 1'b0;
      ack_read_reg   <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      fetch_pend_reg <= grant_core;
      ack_pend_reg   <= grant_wb;
      ack_read_reg   <= grant_wb & ~wbs_we_i;
    end
  end

endmodule

// File: tb/tb_tms_pmem_arbiter.sv
// Testbench for tms_pmem_arbiter: directed vectors with a behavioural SRAM.
// The stimulus process pushes expected response data into queues and checks
// issue timing. A negedge monitor pops the queues and compares each pulse.
module tb_tms_pmem_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        core_halt = 1'b0;
  logic        fetch_req = 1'b0;
  logic [10:0] fetch_addr = '0;
  logic        fetch_valid;
  logic [7:0]  fetch_data;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        mem_csb;
  logic        mem_web;
  logic [10:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  logic [7:0]  sram [0:2047];
  logic [7:0]  fetch_q [$];
  logic [31:0] wb_q [$];
  logic [10:0] t4_addr [6];
  int          total = 0;
  int          passed = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  tms_pmem_arbiter #(.ADDR_W(11), .MAX_WAIT(4)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .core_halt  (core_halt),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .mem_csb    (mem_csb),
    .mem_web    (mem_web),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Behavioural single-port SRAM: registered read, data valid the cycle after issue.
  always @(posedge wb_clk_i) begin
    if (!mem_csb) begin
      if (!mem_web) sram[mem_addr] <= mem_din;
      mem_dout <= sram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wb_drive(input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_adr_i = adr;
    wbs_dat_i = dat;
  endtask

  task automatic wb_idle();
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'h0;
  endtask

  // Monitor: pops an expected value on each response pulse; data is zero otherwise.
  always @(negedge wb_clk_i) begin
    check("valid_ack_exclusive", fetch_valid & wbs_ack_o, 1'b0);
    if (fetch_valid) begin
      if (fetch_q.size() == 0) begin
        check("fetch_unexpected", fetch_valid, 1'b0);
      end else begin
        logic [7:0] e;
        e = fetch_q.pop_front();
        $display("fetch  data=0x%02h expected=0x%02h", fetch_data, e);
        check("fetch_data", fetch_data, e);
      end
    end else begin
      check("fetch_data_idle", fetch_data, 8'h00);
    end
    if (wbs_ack_o) begin
      if (wb_q.size() == 0) begin
        check("wb_ack_unexpected", wbs_ack_o, 1'b0);
      end else begin
        logic [31:0] e;
        e = wb_q.pop_front();
        $display("wb ack data=0x%08h expected=0x%08h", wbs_dat_o, e);
        check("wb_dat", wbs_dat_o, e);
      end
    end else begin
      check("wb_dat_idle", wbs_dat_o, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) sram[i] = 8'h00;
    sram[11'h012] = 8'h3C;
    sram[11'h020] = 8'h5A;
    sram[11'h033] = 8'hC7;
    sram[11'h005] = 8'h99;
    t4_addr = '{11'h033, 11'h033, 11'h033, 11'h033, 11'h020, 11'h033};

    // Reset values, with a fetch and a WB request both pending.
    fetch_req = 1'b1;
    fetch_addr = 11'h012;
    wb_drive(1'b0, 4'hF, 32'h0C, 32'h0);
    repeat (3) tick();
    settle();
    check("rst_fetch_valid", fetch_valid, 1'b0);
    check("rst_fetch_data", fetch_data, 8'h00);
    check("rst_ack", wbs_ack_o, 1'b0);
    check("rst_wb_dat", wbs_dat_o, 32'h0);
    check("rst_csb", mem_csb, 1'b1);
    check("rst_web", mem_web, 1'b1);
    check("rst_addr", mem_addr, 11'h000);
    check("rst_din", mem_din, 8'h00);
    tick();
    wb_rst_i = 1'b0;
    fetch_req = 1'b0;
    wb_idle();
    core_halt = 1'b1;

    // Halted core: WB write then read-back.
    tick();
    wb_drive(1'b1, 4'hF, 32'h0C, 32'hA5);
    settle();
    check("t1_wr_csb", mem_csb, 1'b0);
    check("t1_wr_web", mem_web, 1'b0);
    check("t1_wr_addr", mem_addr, 11'h003);
    check("t1_wr_din", mem_din, 8'hA5);
    wb_q.push_back(32'h0);
    tick();
    settle();
    check("t1_wr_ack", wbs_ack_o, 1'b1);
    check("t1_no_reissue", mem_csb, 1'b1);
    tick();
    wb_idle();
    settle();
    check("t1_sram", sram[3], 8'hA5);
    tick();
    wb_drive(1'b0, 4'hF, 32'h0C, 32'h0);
    settle();
    check("t1_rd_csb", mem_csb, 1'b0);
    check("t1_rd_web", mem_web, 1'b1);
    check("t1_rd_addr", mem_addr, 11'h003);
    wb_q.push_back(32'h0000_00A5);
    tick();
    settle();
    check("t1_rd_ack", wbs_ack_o, 1'b1);
    tick();
    wb_idle();
    core_halt = 1'b0;

    // Single core fetch.
    tick();
    fetch_req = 1'b1;
    fetch_addr = 11'h012;
    settle();
    check("t2_csb", mem_csb, 1'b0);
    check("t2_web", mem_web, 1'b1);
    check("t2_addr", mem_addr, 11'h012);
    fetch_q.push_back(8'h3C);
    tick();
    fetch_req = 1'b0;
    settle();
    check("t2_valid", fetch_valid, 1'b1);
    check("t2_idle_csb", mem_csb, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      settle();
      check("t2_no_second", fetch_valid, 1'b0);
    end

    // Simultaneous request: core first, WB next cycle.
    tick();
    fetch_req = 1'b1;
    fetch_addr = 11'h012;
    wb_drive(1'b0, 4'hF, 32'h80, 32'h0);
    settle();
    check("t3_core_addr", mem_addr, 11'h012);
    check("t3_core_web", mem_web, 1'b1);
    fetch_q.push_back(8'h3C);
    tick();
    fetch_req = 1'b0;
    settle();
    check("t3_wb_csb", mem_csb, 1'b0);
    check("t3_wb_addr", mem_addr, 11'h020);
    check("t3_valid", fetch_valid, 1'b1);
    wb_q.push_back(32'h0000_005A);
    tick();
    settle();
    check("t3_ack", wbs_ack_o, 1'b1);
    check("t3_valid_low", fetch_valid, 1'b0);
    tick();
    wb_idle();

    // Sustained fetch stream with a pending WB read: WB forced on 5th cycle.
    tick();
    fetch_req = 1'b1;
    fetch_addr = 11'h033;
    wb_drive(1'b0, 4'hF, 32'h80, 32'h0);
    for (int p = 0; p < 6; p++) begin
      if (p > 0) tick();
      settle();
      check("t4_csb", mem_csb, 1'b0);
      check("t4_addr", mem_addr, t4_addr[p]);
      check("t4_ack", wbs_ack_o, (p == 5) ? 1'b1 : 1'b0);
      if (p == 4) wb_q.push_back(32'h0000_005A);
      else fetch_q.push_back(8'hC7);
    end
    tick();
    fetch_req = 1'b0;
    wb_idle();
    settle();
    check("t4_last_valid", fetch_valid, 1'b1);
    check("t4_idle_csb", mem_csb, 1'b1);
    tick();

    // Masked byte write: acked, no SRAM access.
    tick();
    wb_drive(1'b1, 4'h0, 32'h14, 32'h11);
    settle();
    check("t5_csb", mem_csb, 1'b1);
    wb_q.push_back(32'h0);
    tick();
    settle();
    check("t5_ack", wbs_ack_o, 1'b1);
    tick();
    wb_idle();
    settle();
    check("t5_sram", sram[5], 8'h99);
    tick();
    wb_drive(1'b0, 4'hF, 32'h14, 32'h0);
    settle();
    check("t5_rd_addr", mem_addr, 11'h005);
    wb_q.push_back(32'h0000_0099);
    tick();
    settle();
    check("t5_rd_ack", wbs_ack_o, 1'b1);
    tick();
    wb_idle();

    // Reset right after a WB grant drops the access.
    tick();
    wb_drive(1'b0, 4'hF, 32'h0C, 32'h0);
    settle();
    check("t6_csb", mem_csb, 1'b0);
    check("t6_addr", mem_addr, 11'h003);
    tick();
    wb_rst_i = 1'b1;
    wb_idle();
    settle();
    check("t6_no_ack", wbs_ack_o, 1'b0);
    check("t6_dat", wbs_dat_o, 32'h0);
    check("t6_rst_csb", mem_csb, 1'b1);
    check("t6_rst_valid", fetch_valid, 1'b0);
    tick();
    wb_rst_i = 1'b0;
    settle();
    check("t6_still_no_ack", wbs_ack_o, 1'b0);
    tick();
    wb_drive(1'b0, 4'hF, 32'h80, 32'h0);
    settle();
    check("t6_new_csb", mem_csb, 1'b0);
    check("t6_new_addr", mem_addr, 11'h020);
    wb_q.push_back(32'h0000_005A);
    tick();
    settle();
    check("t6_new_ack", wbs_ack_o, 1'b1);
    tick();
    wb_idle();
    repeat (3) tick();

    check("fetch_q_drained", fetch_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
